cart_download_ctrl: RTL and testbench

- Sits between the HPS ioctl download stream and cartridge ROM storage in the console core.
- Generalises the single-slot cart loader to SLOTS independently tracked cartridge slots with a configurable address width.
- Per slot it learns a power-of-two address mask in one step per write, reports loaded size and an overflow condition, and registers the write strobe.
- Sequences the post-load "skip logo" reset pulse with parametrised delay and pulse length; the pulse is abortable by a new download.

---
 rtl/cart_download_ctrl.sv | 226 ++++++++++++++++++++++
 tb/tb_cart_download_ctrl.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cart_download_ctrl.sv
// rtl/cart_download_ctrl.sv - multi-slot cartridge download controller with skip-logo reset sequencing
//
// Purpose: takes the ioctl download stream, forwards accepted bytes to cart RAM
// one cycle later, and learns a per-slot power-of-two address mask and loaded size.
// After a completed download with skip_en set, it produces a delayed skip_reset pulse.
//
// Ports:
//   clk_sys, reset                          clock, async active-high reset
//   dl_active, dl_wr, dl_addr, dl_data      download stream
//   dl_index                                target slot of the download
//   skip_en                                 request the skip-logo reset pulse
//   sel_slot                                slot reported on addr_mask / size
//   cart_we, cart_addr, cart_data, cart_slot registered write port to cart RAM
//   addr_mask, size                         learned mask and size of sel_slot
//   loaded                                  per-slot download-completed flags
//   overflow                                sticky dropped-write flag
//   skip_reset                              reset request to the core
module cart_download_ctrl #(
    parameter int ADDR_W     = 15,
    parameter int SLOTS      = 2,
    parameter int SKIP_DELAY = 5000000,
    parameter int SKIP_PULSE = 1000
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic              dl_active,
    input  logic              dl_wr,
    input  logic [24:0]       dl_addr,
    input  logic [7:0]        dl_data,
    input  logic [7:0]        dl_index,
    input  logic              skip_en,
    input  logic [2:0]        sel_slot,
    output logic              cart_we,
    output logic [ADDR_W-1:0] cart_addr,
    output logic [7:0]        cart_data,
    output logic [2:0]        cart_slot,
    output logic [ADDR_W-1:0] addr_mask,
    output logic [ADDR_W:0]   size,
    output logic [SLOTS-1:0]  loaded,
    output logic              overflow,
    output logic              skip_reset
);

    typedef enum logic [1:0] {IDLE, LOAD, WAIT, PULSE} state_t;

    localparam int WAIT_CYC = SKIP_DELAY - SKIP_PULSE;

    state_t              state_q, state_d;
    logic                dl_active_q, dl_active_d;
    logic [7:0]          tgt_q, tgt_d;
    logic [31:0]         cnt_q, cnt_d;
    logic [ADDR_W-1:0]   mask_q [SLOTS];
    logic [ADDR_W-1:0]   mask_d [SLOTS];
    logic [ADDR_W:0]     size_q [SLOTS];
    logic [ADDR_W:0]     size_d [SLOTS];
    logic [SLOTS-1:0]    loaded_q, loaded_d;
    logic                overflow_q, overflow_d;
    logic                cart_we_q, cart_we_d;
    logic [ADDR_W-1:0]   cart_addr_q, cart_addr_d;
    logic [7:0]          cart_data_q, cart_data_d;
    logic [2:0]          cart_slot_q, cart_slot_d;
    logic                skip_q, skip_d;

    logic                rise;
    logic                fall;
    logic [7:0]          tgt;
    logic                tgt_ok;
    logic                addr_oor;
    logic [ADDR_W-1:0]   a;
    logic [ADDR_W:0]     a_p1;

    // Fill every bit at and below the highest set bit: smallest 2^n-1 covering a.
    function automatic logic [ADDR_W-1:0] smear(input logic [ADDR_W-1:0] v);
        logic [ADDR_W-1:0] s;
        s = v;
        for (int i = ADDR_W - 2; i >= 0; i--) begin
            s[i] = s[i+1] | v[i];
        end
        return s;
    endfunction

    always_comb begin
        state_d     = state_q;
        dl_active_d = dl_active;
        tgt_d       = tgt_q;
        cnt_d       = cnt_q;
        mask_d      = mask_q;
        size_d      = size_q;
        loaded_d    = loaded_q;
        overflow_d  = overflow_q;
        cart_we_d   = 1'b0;
        cart_addr_d = cart_addr_q;
        cart_data_d = cart_data_q;
        cart_slot_d = cart_slot_q;
        skip_d      = skip_q;

        rise     = dl_active & ~dl_active_q;
        fall     = ~dl_active & dl_active_q;
        // On the rising-edge cycle the new index applies immediately.
        tgt      = rise ? dl_index : tgt_q;
        tgt_ok   = (tgt < 8'(SLOTS));
        addr_oor = ((dl_addr >> ADDR_W) != 25'd0);
        a        = dl_addr[ADDR_W-1:0];
        a_p1     = {1'b0, a} + (ADDR_W+1)'(1);

        if (rise) begin
            state_d = LOAD;
            tgt_d   = dl_index;
            cnt_d   = 32'd0;
            skip_d  = 1'b0;
            if (tgt_ok) begin
                overflow_d = 1'b0;
                for (int i = 0; i < SLOTS; i++) begin
                    if (tgt == 8'(i)) begin
                        mask_d[i]   = '0;
                        size_d[i]   = '0;
                        loaded_d[i] = 1'b0;
                    end
                end
            end
        end else begin
            case (state_q)
                LOAD: begin
                    if (fall) begin
                        for (int i = 0; i < SLOTS; i++) begin
                            if (tgt == 8'(i)) loaded_d[i] = 1'b1;
                        end
                        cnt_d   = 32'd0;
                        state_d = (skip_en && tgt_ok) ? WAIT : IDLE;
                    end
                end
                WAIT: begin
                    if (cnt_q == 32'(WAIT_CYC - 1)) begin
                        cnt_d   = 32'd0;
                        skip_d  = 1'b1;
                        state_d = PULSE;
                    end else begin
                        cnt_d = cnt_q + 32'd1;
                    end
                end
                PULSE: begin
                    if (cnt_q == 32'(SKIP_PULSE - 1)) begin
                        cnt_d   = 32'd0;
                        skip_d  = 1'b0;
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q + 32'd1;
                    end
                end
                default: ;
            endcase
        end

        // Writes build on mask_d/size_d so the rising-edge clear is the base.
        if ((state_q == LOAD || rise) && dl_wr) begin
            if (!tgt_ok || addr_oor) begin
                overflow_d = 1'b1;
            end else begin
                for (int i = 0; i < SLOTS; i++) begin
                    if (tgt == 8'(i)) begin
                        mask_d[i] = mask_d[i] | smear(a);
                        if (a_p1 > size_d[i]) size_d[i] = a_p1;
                    end
                end
                cart_we_d   = 1'b1;
                cart_addr_d = a;
                cart_data_d = dl_data;
                cart_slot_d = tgt[2:0];
            end
        end
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            dl_active_q <= 1'b0;
            tgt_q       <= 8'd0;
            cnt_q       <= 32'd0;
            for (int i = 0; i < SLOTS; i++) begin
                mask_q[i] <= '0;
                size_q[i] <= '0;
            end
            loaded_q    <= '0;
            overflow_q  <= 1'b0;
            cart_we_q   <= 1'b0;
            cart_addr_q <= '0;
            cart_data_q <= 8'd0;
            cart_slot_q <= 3'd0;
            skip_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            dl_active_q <= dl_active_d;
            tgt_q       <= tgt_d;
            cnt_q       <= cnt_d;
            mask_q      <= mask_d;
            size_q      <= size_d;
            loaded_q    <= loaded_d;
            overflow_q  <= overflow_d;
            cart_we_q   <= cart_we_d;
            cart_addr_q <= cart_addr_d;
            cart_data_q <= cart_data_d;
            cart_slot_q <= cart_slot_d;
            skip_q      <= skip_d;
        end
    end

    always_comb begin
        addr_mask = '0;
        size      = '0;
        for (int i = 0; i < SLOTS; i++) begin
            if (sel_slot == 3'(i)) begin
                addr_mask = mask_q[i];
                size      = size_q[i];
            end
        end
    end

    assign cart_we    = cart_we_q;
    assign cart_addr  = cart_addr_q;
    assign cart_data  = cart_data_q;
    assign cart_slot  = cart_slot_q;
    assign loaded     = loaded_q;
    assign overflow   = overflow_q;
    assign skip_reset = skip_q;

endmodule

// File: tb/tb_cart_download_ctrl.sv
// tb/tb_cart_download_ctrl.sv - scoreboard bench for cart_download_ctrl
module tb_cart_download_ctrl;

    logic        clk_sys = 1'b0;
    logic        reset;
    logic        dl_active, dl_wr, skip_en;
    logic [24:0] dl_addr;
    logic [7:0]  dl_data, dl_index;
    logic [2:0]  sel_slot;
    logic        cart_we;
    logic [14:0] cart_addr;
    logic [7:0]  cart_data;
    logic [2:0]  cart_slot;
    logic [14:0] addr_mask;
    logic [15:0] size;
    logic [1:0]  loaded;
    logic        overflow, skip_reset;

    cart_download_ctrl #(.ADDR_W(15), .SLOTS(2), .SKIP_DELAY(20), .SKIP_PULSE(5)) dut (
        .clk_sys(clk_sys), .reset(reset), .dl_active(dl_active), .dl_wr(dl_wr),
        .dl_addr(dl_addr), .dl_data(dl_data), .dl_index(dl_index), .skip_en(skip_en),
        .sel_slot(sel_slot), .cart_we(cart_we), .cart_addr(cart_addr), .cart_data(cart_data),
        .cart_slot(cart_slot), .addr_mask(addr_mask), .size(size), .loaded(loaded),
        .overflow(overflow), .skip_reset(skip_reset)
    );

    always #5 clk_sys = ~clk_sys;

    int cyc = 0;
    always @(posedge clk_sys) cyc <= cyc + 1;

    int skip_hi = 0;
    always @(negedge clk_sys) if (skip_reset) skip_hi <= skip_hi + 1;

    typedef struct {
        logic [14:0] addr;
        logic [7:0]  data;
        logic [2:0]  slot;
        int          edge_no;
    } exp_t;
    exp_t sbq[$];

    int tests = 0;
    int fails = 0;
    int we_cnt = 0;
    int fall_edge = 0;
    int snap_skip, snap_we;
    int rise_at;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_slot(input logic [2:0] s, input logic [31:0] m, input logic [31:0] sz);
        sel_slot = s;
        #1;
        chk($sformatf("mask_slot%0d", s), 32'(addr_mask), m);
        chk($sformatf("size_slot%0d", s), 32'(size), sz);
    endtask

    task automatic begin_dl(input logic [7:0] idx, input bit sk, input bit wr,
                            input logic [24:0] addr, input logic [7:0] data);
        @(negedge clk_sys);
        dl_active = 1'b1;
        dl_index  = idx;
        skip_en   = sk;
        dl_wr     = wr;
        dl_addr   = addr;
        dl_data   = data;
        if (wr && idx < 8'd2 && addr < 25'h8000)
            sbq.push_back('{addr[14:0], data, idx[2:0], cyc + 1});
    endtask

    task automatic do_wr(input logic [24:0] addr, input logic [7:0] data, input bit ok);
        @(negedge clk_sys);
        dl_wr   = 1'b1;
        dl_addr = addr;
        dl_data = data;
        if (ok) sbq.push_back('{addr[14:0], data, dl_index[2:0], cyc + 1});
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk_sys);
            dl_wr = 1'b0;
        end
    endtask

    task automatic end_dl();
        @(negedge clk_sys);
        dl_wr     = 1'b0;
        dl_active = 1'b0;
        fall_edge = cyc + 1;
    endtask

    // Waits (bounded) for skip_reset and checks it rises 15 cycles after the fall.
    task automatic wait_skip_rise(output int at);
        at = -1;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk_sys);
            if (skip_reset) begin
                at = cyc;
                break;
            end
        end
        chk("skip_rise_cycle", 32'(at), 32'(fall_edge + 15));
    endtask

    task automatic skip_len_check();
        int d;
        d = 1;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk_sys);
            if (!skip_reset) break;
            d++;
        end
        chk("skip_pulse_len", 32'(d), 32'd5);
    endtask

    task automatic stimulus();
        reset = 1'b1; dl_active = 1'b0; dl_wr = 1'b0; dl_addr = '0; dl_data = '0;
        dl_index = '0; skip_en = 1'b0; sel_slot = 3'd0;
        repeat (3) @(negedge clk_sys);
        chk("rst_cart_we", 32'(cart_we), 0);
        chk("rst_mask", 32'(addr_mask), 0);
        chk("rst_size", 32'(size), 0);
        chk("rst_loaded", 32'(loaded), 0);
        chk("rst_overflow", 32'(overflow), 0);
        chk("rst_skip", 32'(skip_reset), 0);
        reset = 1'b0;

        // 4 KiB sequential load into slot 0, first byte on the rising-edge cycle
        snap_skip = skip_hi;
        begin_dl(8'd0, 1'b0, 1'b1, 25'd0, 8'h5A);
        for (int i = 1; i < 4096; i++) do_wr(25'(i), 8'(i) ^ 8'h5A, 1'b1);
        end_dl();
        idle(3);
        chk_slot(3'd0, 32'h0FFF, 32'h1000);
        chk("t1_loaded", 32'(loaded), 32'h1);
        chk("t1_overflow", 32'(overflow), 0);
        chk("t1_we_count", 32'(we_cnt), 32'd4096);
        chk("t1_no_skip", 32'(skip_hi - snap_skip), 0);

        // single write into slot 1
        begin_dl(8'd1, 1'b0, 1'b0, 25'd0, 8'd0);
        do_wr(25'h2345, 8'hA7, 1'b1);
        end_dl();
        idle(2);
        chk_slot(3'd1, 32'h3FFF, 32'h2346);
        chk_slot(3'd0, 32'h0FFF, 32'h1000);
        chk("t2_loaded", 32'(loaded), 32'h3);

        // out-of-range address
        snap_we = we_cnt;
        begin_dl(8'd1, 1'b0, 1'b0, 25'd0, 8'd0);
        do_wr(25'h0010, 8'h11, 1'b1);
        do_wr(25'h8000, 8'h22, 1'b0);
        idle(2);
        chk("t3_overflow", 32'(overflow), 1);
        chk_slot(3'd1, 32'h001F, 32'h0011);
        chk("t3_we_delta", 32'(we_cnt - snap_we), 1);
        end_dl();
        idle(2);
        chk("t3_overflow_sticky", 32'(overflow), 1);

        // skip-logo sequence; the new download also clears overflow
        begin_dl(8'd1, 1'b1, 1'b0, 25'd0, 8'd0);
        idle(1);
        chk("t4_overflow_clr", 32'(overflow), 0);
        do_wr(25'h0003, 8'h33, 1'b1);
        end_dl();
        wait_skip_rise(rise_at);
        skip_len_check();
        chk_slot(3'd1, 32'h0003, 32'h0004);
        chk("t4_loaded", 32'(loaded), 32'h3);
        idle(5);

        // abort the pulse with a new download at pulse cycle 2
        begin_dl(8'd1, 1'b1, 1'b0, 25'd0, 8'd0);
        do_wr(25'h0008, 8'h34, 1'b1);
        end_dl();
        wait_skip_rise(rise_at);
        begin_dl(8'd1, 1'b0, 1'b1, 25'h0040, 8'h44);
        idle(1);
        chk("t5_abort_skip_low", 32'(skip_reset), 0);
        snap_skip = skip_hi;
        end_dl();
        idle(40);
        chk("t5_no_skip_after", 32'(skip_hi - snap_skip), 0);
        chk_slot(3'd1, 32'h007F, 32'h0041);

        // out-of-range slot
        snap_we = we_cnt;
        begin_dl(8'd5, 1'b1, 1'b1, 25'h0010, 8'h55);
        do_wr(25'h0020, 8'h66, 1'b0);
        idle(1);
        chk("t6_overflow", 32'(overflow), 1);
        snap_skip = skip_hi;
        end_dl();
        idle(40);
        chk("t6_loaded", 32'(loaded), 32'h3);
        chk("t6_no_skip", 32'(skip_hi - snap_skip), 0);
        chk("t6_no_we", 32'(we_cnt - snap_we), 0);
        chk_slot(3'd1, 32'h007F, 32'h0041);
        chk_slot(3'd0, 32'h0FFF, 32'h1000);
        chk_slot(3'd5, 32'h0, 32'h0);

        // reset mid-LOAD
        sel_slot = 3'd1;
        begin_dl(8'd1, 1'b0, 1'b1, 25'h1234, 8'h77);
        do_wr(25'h0ABC, 8'h88, 1'b1);
        idle(1);
        chk("t7_pre_addr", 32'(cart_addr), 32'h0ABC);
        #2 reset = 1'b1;
        #1;
        chk("t7_cart_we", 32'(cart_we), 0);
        chk("t7_cart_addr", 32'(cart_addr), 0);
        chk("t7_cart_data", 32'(cart_data), 0);
        chk("t7_cart_slot", 32'(cart_slot), 0);
        chk("t7_mask", 32'(addr_mask), 0);
        chk("t7_size", 32'(size), 0);
        chk("t7_loaded", 32'(loaded), 0);
        chk("t7_overflow", 32'(overflow), 0);
        dl_active = 1'b0;
        @(negedge clk_sys);
        reset = 1'b0;
        begin_dl(8'd0, 1'b0, 1'b1, 25'h0005, 8'h99);
        end_dl();
        idle(2);
        chk_slot(3'd0, 32'h0007, 32'h0006);
        chk_slot(3'd1, 32'h0, 32'h0);
        chk("t7_loaded_after", 32'(loaded), 32'h1);

        // reset mid-PULSE
        begin_dl(8'd0, 1'b1, 1'b0, 25'd0, 8'd0);
        do_wr(25'h0002, 8'hAB, 1'b1);
        end_dl();
        wait_skip_rise(rise_at);
        #2 reset = 1'b1;
        #1;
        chk("t8_skip", 32'(skip_reset), 0);
        chk("t8_loaded", 32'(loaded), 0);
        @(negedge clk_sys);
        reset = 1'b0;
        snap_skip = skip_hi;
        idle(40);
        chk("t8_no_skip_after", 32'(skip_hi - snap_skip), 0);

        idle(3);
        chk("sb_empty", 32'(sbq.size()), 0);
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk_sys);
            if (cart_we) begin
                we_cnt++;
                if (sbq.size() == 0) begin
                    chk("unexpected_cart_we", 32'(cart_addr), 32'hFFFF_FFFF);
                end else begin
                    e = sbq.pop_front();
                    chk("we_addr", 32'(cart_addr), 32'(e.addr));
                    chk("we_data", 32'(cart_data), 32'(e.data));
                    chk("we_slot", 32'(cart_slot), 32'(e.slot));
                    chk("we_latency", 32'(cyc), 32'(e.edge_no));
                end
            end
        end
    endtask

    initial begin
        fork
            monitor();
            stimulus();
        join_any
        disable fork;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
